// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared constants and state encoding for the Beta boot loader
package beta_pkg;
    localparam int WORD_WIDTH = 32;
    localparam int BYTE_WIDTH = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    // States in which the loader consumes bytes from the stream.
    function automatic logic is_loading(input logic [2:0] s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction
endpackage

// File: rtl/boot_word_assembler.sv
// rtl/boot_word_assembler.sv - little-endian byte-to-word shifter with running XOR checksum
module boot_word_assembler
    import beta_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    output logic [1:0]            lane,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_valid,
    output logic [BYTE_WIDTH-1:0] checksum
);
    logic [WORD_WIDTH-1:0] shift;
    logic [WORD_WIDTH-1:0] shift_next;

    // New bytes enter at the top so the first byte ends up in bits 7:0.
    assign shift_next = {byte_data, shift[WORD_WIDTH-1:BYTE_WIDTH]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift      <= '0;
            lane       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            checksum   <= '0;
        end else if (clear) begin
            shift      <= '0;
            lane       <= '0;
            word_valid <= 1'b0;
            checksum   <= '0;
        end else begin
            word_valid <= byte_en && (lane == 2'd3);
            if (byte_en) begin
                shift    <= shift_next;
                lane     <= lane + 2'd1;
                checksum <= checksum ^ byte_data;
                if (lane == 2'd3) begin
                    word <= shift_next;
                end
            end
        end
    end
endmodule

// File: rtl/beta_boot_loader.sv
// rtl/beta_boot_loader.sv - streams a checksummed program image into instruction memory and releases the CPU
module beta_boot_loader
    import beta_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  runCPU,
    output logic                  busy,
    output logic                  error
);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [16:0] word_count;
    logic [16:0] hdr_len;
    logic        accept;
    logic        load_go;
    logic        byte_en;
    logic        word_end;
    logic [1:0]  lane;
    logic [7:0]  checksum;

    assign accept   = rx_valid && rx_ready;
    assign load_go  = start && ((state == ST_IDLE) || (state == ST_ERROR));
    assign byte_en  = accept && (state == ST_DATA);
    assign word_end = byte_en && (lane == 2'd3);
    assign hdr_len  = {1'b0, rx_data, len_lo};

    boot_word_assembler u_asm (
        .clk        (clk),
        .resetn     (reset),
        .clear      (load_go),
        .byte_en    (byte_en),
        .byte_data  (rx_data),
        .lane       (lane),
        .word       (imem_wdata),
        .word_valid (imem_we),
        .checksum   (checksum)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_ERROR: if (start) next_state = ST_LEN_LO;
            ST_LEN_LO: if (accept) next_state = ST_LEN_HI;
            ST_LEN_HI: begin
                if (accept) begin
                    if (hdr_len > MAX_WORDS)  next_state = ST_ERROR;
                    else if (hdr_len == '0)   next_state = ST_CHECK;
                    else                      next_state = ST_DATA;
                end
            end
            ST_DATA: if (word_end && (word_count + 17'd1 == {1'b0, len})) next_state = ST_CHECK;
            ST_CHECK: if (accept) next_state = (rx_data == checksum) ? ST_RUN : ST_ERROR;
            default: next_state = state;
        endcase
    end

    // Status outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rx_ready   <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
            runCPU     <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            word_count <= '0;
            imem_addr  <= '0;
        end else begin
            state    <= next_state;
            rx_ready <= is_loading(next_state);
            busy     <= is_loading(next_state);
            error    <= (next_state == ST_ERROR);
            runCPU   <= (next_state == ST_RUN);
            if (load_go) begin
                word_count <= '0;
                imem_addr  <= '0;
            end
            if (accept && (state == ST_LEN_LO)) len_lo <= rx_data;
            if (accept && (state == ST_LEN_HI)) len <= hdr_len[15:0];
            if (word_end) begin
                imem_addr  <= word_count[ADDR_WIDTH-1:0];
                word_count <= word_count + 17'd1;
            end
        end
    end
endmodule

// File: tb/tb_beta_boot_loader.sv
// tb/tb_beta_boot_loader.sv - randomized scoreboard bench for beta_boot_loader
module tb_beta_boot_loader;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          runCPU;
    logic          busy;
    logic          error;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img[0:1023];

    beta_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .runCPU     (runCPU),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write from the model.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", imem_addr, imem_wdata);
            end else begin
                check("imem_write", 64'({imem_addr, imem_wdata}), exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rx_valid = 1'b0;
        start    = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int t;
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout actual=rx_ready_low required=rx_ready_high");
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Reference model: image = header, little-endian words, XOR of payload bytes.
    task automatic load(input int n, input logic [7:0] chk_xor, input int max_gap);
        logic [15:0] nn;
        logic [7:0]  chk;
        logic [31:0] w;
        nn  = 16'(n);
        chk = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(64'({10'(i), img[i]}));
            w = img[i];
            chk = chk ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        check("pre_load_run", 64'(runCPU), 64'(0));
        pulse_start();
        check("busy_after_start", 64'({busy, rx_ready, error}), 64'(3'b110));
        send_byte(nn[7:0], max_gap);
        send_byte(nn[15:8], max_gap);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[7:0], max_gap);
                w = w >> 8;
            end
        end
        send_byte(chk ^ chk_xor, max_gap);
        rx_valid = 1'b0;
        check("outcome_run_err", 64'({runCPU, error}), (chk_xor == 0) ? 64'(2'b10) : 64'(2'b01));
        check("idle_handshake", 64'({rx_ready, busy}), 64'(0));
        check("writes_all_seen", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] w;
        int n;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({rx_ready, imem_we, imem_addr, imem_wdata, runCPU, busy, error}), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        img[0] = 32'hE000_0013;
        img[1] = 32'h0000_0000;
        load(2, 8'h00, 0);
        pulse_start();
        check("start_ignored_in_run", 64'({runCPU, rx_ready, error}), 64'(3'b100));

        // Bad checksum: F3 ^ F3 sends 00; then reload from ERROR.
        do_reset();
        load(2, 8'hF3, 0);
        load(2, 8'h00, 0);

        do_reset();
        load(0, 8'h00, 0);

        // Oversize header N = 1025.
        do_reset();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        rx_valid = 1'b0;
        check("oversize_state", 64'({error, rx_ready, busy, runCPU}), 64'(4'b1000));
        repeat (3) @(negedge clk);
        check("oversize_hold", 64'({error, rx_ready, runCPU}), 64'(3'b100));

        // Nominal image with random stalls.
        do_reset();
        img[0] = 32'hE000_0013;
        img[1] = 32'h0000_0000;
        load(2, 8'h00, 4);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) img[i] = $urandom;
            if (r == 2) begin
                load(n, 8'($urandom_range(1, 255)), 3);
                for (int i = 0; i < n; i++) img[i] = $urandom;
            end
            load(n, 8'h00, (r == 1) ? 0 : 3);
        end

        // Reset after 5 payload bytes: only word 0 may have been written.
        do_reset();
        img[0] = $urandom;
        exp_q.push_back(64'({10'd0, img[0]}));
        pulse_start();
        send_byte(8'h02, 2);
        send_byte(8'h00, 2);
        w = img[0];
        for (int k = 0; k < 4; k++) begin
            send_byte(w[7:0], 2);
            w = w >> 8;
        end
        send_byte(8'hA5, 2);
        rx_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_outputs", 64'({rx_ready, imem_we, imem_addr, imem_wdata, runCPU, busy, error}), 64'(0));
        check("midreset_writes", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        img[0] = 32'hE000_0013;
        img[1] = 32'h0000_0000;
        load(2, 8'h00, 1);

        // Exact fill: last write lands on address 1023.
        do_reset();
        for (int i = 0; i < 1024; i++) img[i] = $urandom;
        load(1024, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
